// File: rtl/keypad_hex_entry_if.sv
// keypad_hex_entry_if: keypad matrix lines, key events and entry register of the hex keypad front end
interface keypad_hex_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] num;
    modport master (input col, clr, output row, key_valid, key_code, key_down, num);
    modport slave (output col, clr, input row, key_valid, key_code, key_down, num);
endinterface

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 keypad, debounces whole frames and shifts accepted hex codes into num
module keypad_hex_entry #(
    parameter int SCAN_DIV = 2500,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    keypad_hex_entry_if.master bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);
    typedef enum logic {IDLE, HELD} state_t;
    typedef enum logic [1:0] {R_NONE, R_SINGLE, R_MULTI} kind_t;
    state_t        state, state_nx;
    kind_t         kind, prev_kind;
    logic [3:0]    col_s1, col_s2;
    logic [CW-1:0] cnt;
    logic [1:0]    r;
    logic [11:0]   acc;
    logic [15:0]   frame_bits;
    logic [4:0]    ones;
    logic [3:0]    code, prev_code, stable_cnt, stable_nx;
    logic          dwell_end, frame_end, accept, release_key;

    assign dwell_end = cnt == CW'(SCAN_DIV - 1);
    assign frame_end = dwell_end && r == 2'd3;
    assign bus.row = ~(4'b0001 << r);

    // two-flop synchroniser on the asynchronous column lines
    always_ff @(posedge clk or posedge rst)
        if (rst) {col_s2, col_s1} <= '0;
        else {col_s2, col_s1} <= {col_s1, bus.col};

    // row dwell counter, row index and shift-in of each row's pressed columns (row 0 ends in [3:0])
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            r <= '0;
            acc <= '0;
        end else begin
            cnt <= dwell_end ? '0 : cnt + 1'b1;
            if (dwell_end) begin
                r <= r + 2'd1;
                acc <= {~col_s2, acc[11:4]};
            end
        end

    // classify the frame from rows 0..2 plus the row-3 sample taken this cycle, and the next stable count
    always_comb begin
        frame_bits = {~col_s2, acc};
        ones = '0;
        code = '0;
        for (int i = 0; i < 16; i++)
            if (frame_bits[i]) begin
                ones = ones + 5'd1;
                code = 4'(i);
            end
        kind = ones == 5'd0 ? R_NONE : ones == 5'd1 ? R_SINGLE : R_MULTI;
        if (kind != R_SINGLE) code = '0;
        stable_nx = (stable_cnt != 4'd0 && kind == prev_kind && code == prev_code) ?
                    (stable_cnt == DF ? DF : stable_cnt + 4'd1) : 4'd1;
    end

    // previous frame result and its run length; a zero count marks "no frame since reset"
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stable_cnt <= '0;
            prev_kind <= R_NONE;
            prev_code <= '0;
        end else if (frame_end) begin
            stable_cnt <= stable_nx;
            prev_kind <= kind;
            prev_code <= code;
        end

    // press/release state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // accept a debounced single key from IDLE; leave HELD only on a debounced release
    always_comb begin
        accept = frame_end && state == IDLE && kind == R_SINGLE && stable_nx == DF;
        release_key = frame_end && state == HELD && kind == R_NONE && stable_nx == DF;
        state_nx = accept ? HELD : release_key ? IDLE : state;
    end

    // key event outputs and entry register; clr overrides a coincident shift
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.key_valid <= 1'b0;
            bus.key_code <= '0;
            bus.key_down <= 1'b0;
            bus.num <= '0;
        end else begin
            bus.key_valid <= accept;
            if (accept) bus.key_code <= code;
            bus.key_down <= accept | (bus.key_down & ~release_key);
            bus.num <= bus.clr ? '0 : accept ? {bus.num[11:0], code} : bus.num;
        end
endmodule
